// File: rtl/usb_rx_unstuff_shift_pkg.sv
// Shared USB receive-path definitions: state encoding and protocol constants
// used by the unstuff, CRC and PID stages.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } rx_state_t;

    localparam int USB_STUFF_LIMIT = 6;
    localparam int USB_BYTE_BITS   = 8;

endpackage

// File: rtl/usb_rx_unstuff_shift_if.sv
// Bit-level receive bus between the NRZI decoder side and the unstuff/shift stage.
interface usb_rx_unstuff_shift_if
    import usb_rx_pkg::*;
#(
    parameter int DATA_BITS = USB_BYTE_BITS
);

    logic                 d_orig;
    logic                 shift_strobe;
    logic                 start;
    logic                 eop;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_ready;
    logic                 stuff_err;
    logic                 align_err;
    logic                 busy;

    modport master (
        output d_orig, shift_strobe, start, eop,
        input  rx_byte, byte_ready, stuff_err, align_err, busy
    );

    modport slave (
        input  d_orig, shift_strobe, start, eop,
        output rx_byte, byte_ready, stuff_err, align_err, busy
    );

endinterface

// File: rtl/usb_rx_unstuff_shift_stuff_detect.sv
// Counts consecutive received 1s and classifies the bit that follows a full run
// as either a droppable stuff bit or a stuffing violation.
module usb_stuff_detect
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic d_orig,
    input  logic shift_strobe,
    input  logic clear,
    input  logic load_one,
    output logic drop_bit,
    output logic stuff_violation
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);

    logic [OW-1:0] ones_cnt_r;
    logic [OW-1:0] ones_cnt_nxt_s;
    logic          at_limit_s;

    assign at_limit_s = (ones_cnt_r == OW'(STUFF_LIMIT));

    // Run-length update and stuff-point classification
    always_comb begin
        ones_cnt_nxt_s  = ones_cnt_r;
        drop_bit        = 1'b0;
        stuff_violation = 1'b0;
        if (clear) begin
            ones_cnt_nxt_s = '0;
        end else if (load_one) begin
            // The last SYNC bit is a 1 and already counts toward the run.
            ones_cnt_nxt_s = OW'(1);
        end else if (shift_strobe) begin
            if (at_limit_s) begin
                if (d_orig) begin
                    stuff_violation = 1'b1;
                end else begin
                    drop_bit       = 1'b1;
                    ones_cnt_nxt_s = '0;
                end
            end else if (d_orig) begin
                ones_cnt_nxt_s = ones_cnt_r + OW'(1);
            end else begin
                ones_cnt_nxt_s = '0;
            end
        end else begin
            ones_cnt_nxt_s = ones_cnt_r;
        end
    end

    // Run-length register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_r <= '0;
        end else begin
            ones_cnt_r <= ones_cnt_nxt_s;
        end
    end

endmodule

// File: rtl/usb_rx_unstuff_shift.sv
// USB receive unstuff stage: drops stuff bits, assembles LSB-first bytes and
// reports stuffing violations and packets ending mid-byte.
module usb_rx_unstuff_shift
    import usb_rx_pkg::*;
#(
    parameter int DATA_BITS   = USB_BYTE_BITS,
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input logic             clk,
    input logic             rst,
    usb_rx_unstuff_shift_if.slave rx
);

    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    rx_state_t            state_r;
    rx_state_t            state_nxt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic [CW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] rx_byte_r;
    logic                 byte_ready_r;
    logic                 stuff_err_r;
    logic                 align_err_r;
    logic                 busy_r;
    logic                 run_strobe_s;
    logic                 drop_bit_s;
    logic                 violation_s;
    logic                 shift_en_s;
    logic                 byte_done_s;

    // eop and start pre-empt any strobe arriving in the same cycle.
    assign run_strobe_s = (state_r == RUN) && rx.shift_strobe && !rx.eop && !rx.start;
    assign shift_en_s   = run_strobe_s && !drop_bit_s && !violation_s;
    assign byte_done_s  = shift_en_s && (bit_cnt_r == LAST_BIT);
    assign shift_nxt_s  = {rx.d_orig, shift_r[DATA_BITS-1:1]};

    usb_stuff_detect #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_stuff_detect (
        .clk             (clk),
        .rst             (rst),
        .d_orig          (rx.d_orig),
        .shift_strobe    (run_strobe_s),
        .clear           (rx.eop),
        .load_one        (rx.start),
        .drop_bit        (drop_bit_s),
        .stuff_violation (violation_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx.eop)        state_nxt_s = IDLE;
                else if (rx.start) state_nxt_s = RUN;
                else               state_nxt_s = IDLE;
            end
            RUN: begin
                if (rx.eop)           state_nxt_s = IDLE;
                else if (rx.start)    state_nxt_s = RUN;
                else if (violation_s) state_nxt_s = ERR;
                else                  state_nxt_s = RUN;
            end
            ERR: begin
                if (rx.eop)        state_nxt_s = IDLE;
                else if (rx.start) state_nxt_s = RUN;
                else               state_nxt_s = ERR;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: shift register, bit counter, byte output and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            rx_byte_r    <= '0;
            byte_ready_r <= 1'b0;
            stuff_err_r  <= 1'b0;
            align_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            byte_ready_r <= 1'b0;
            align_err_r  <= 1'b0;
            busy_r       <= (state_nxt_s != IDLE);
            if (rx.eop) begin
                shift_r     <= '0;
                bit_cnt_r   <= '0;
                stuff_err_r <= 1'b0;
                align_err_r <= (state_r == RUN) && (bit_cnt_r != '0);
            end else if (rx.start) begin
                shift_r     <= '0;
                bit_cnt_r   <= '0;
                stuff_err_r <= 1'b0;
            end else if (violation_s) begin
                stuff_err_r <= 1'b1;
            end else if (shift_en_s) begin
                shift_r <= shift_nxt_s;
                if (byte_done_s) begin
                    bit_cnt_r    <= '0;
                    rx_byte_r    <= shift_nxt_s;
                    byte_ready_r <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                end
            end
        end
    end

    assign rx.rx_byte    = rx_byte_r;
    assign rx.byte_ready = byte_ready_r;
    assign rx.stuff_err  = stuff_err_r;
    assign rx.align_err  = align_err_r;
    assign rx.busy       = busy_r;

endmodule

// File: tb/tb_usb_rx_unstuff_shift.sv
// Self-checking bench for usb_rx_unstuff_shift: byte scoreboard plus
// per-scenario status checks.
module tb_usb_rx_unstuff_shift;
    import usb_rx_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];
    logic align_exp = 1'b0;

    always #5 clk = ~clk;

    usb_rx_unstuff_shift_if bus ();

    usb_rx_unstuff_shift dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    // Advance one clock, then check byte_ready against the scoreboard and align_err.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (bus.byte_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_ready unexpected: rx_byte=%h, none expected", bus.rx_byte);
            end else begin
                e = exp_q.pop_front();
                if (bus.rx_byte !== e) begin
                    errors++;
                    $display("FAIL rx_byte: got %h expected %h", bus.rx_byte, e);
                end
            end
        end
        if (bus.align_err || align_exp) begin
            checks++;
            if (bus.align_err !== align_exp) begin
                errors++;
                $display("FAIL align_err: got %b expected %b", bus.align_err, align_exp);
            end
        end
        align_exp = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.d_orig       = b;
        bus.shift_strobe = 1'b1;
        tick();
        bus.shift_strobe = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        exp_q.push_back(v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_eop(input logic expect_align);
        bus.eop   = 1'b1;
        align_exp = expect_align;
        tick();
        bus.eop   = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected bytes never arrived", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.d_orig = 1'b0; bus.shift_strobe = 1'b0; bus.start = 1'b0; bus.eop = 1'b0;
        #1 rst = 1'b1;
        #12;
        checks++;
        if (bus.rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_byte: got %h expected 00", bus.rx_byte);
        end
        check_bit("reset_byte_ready", bus.byte_ready, 1'b0);
        check_bit("reset_stuff_err", bus.stuff_err, 1'b0);
        check_bit("reset_align_err", bus.align_err, 1'b0);
        check_bit("reset_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_byte_a5();
        pulse_start();
        check_bit("a5_busy", bus.busy, 1'b1);
        send_byte(8'hA5);
        check_drained("a5_byte");
        check_bit("a5_stuff_err", bus.stuff_err, 1'b0);
        do_eop(1'b0);
        check_bit("a5_idle", bus.busy, 1'b0);
    endtask

    task automatic test_stuff_drop();
        pulse_start();
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check_drained("drop_byte");
        check_bit("drop_stuff_err", bus.stuff_err, 1'b0);
        check_bit("drop_busy", bus.busy, 1'b1);
        do_eop(1'b0);
    endtask

    task automatic test_stuff_violation();
        pulse_start();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        check_bit("viol_stuff_err", bus.stuff_err, 1'b1);
        check_bit("viol_busy", bus.busy, 1'b1);
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        check_bit("viol_sticky", bus.stuff_err, 1'b1);
        bus.eop = 1'b1;
        #1;
        check_bit("viol_visible_in_eop", bus.stuff_err, 1'b1);
        tick();
        bus.eop = 1'b0;
        check_bit("viol_cleared", bus.stuff_err, 1'b0);
        check_bit("viol_idle", bus.busy, 1'b0);
        check_drained("viol_no_byte");
    endtask

    task automatic test_partial_eop();
        pulse_start();
        send_byte(8'h3C);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_eop(1'b1);
        check_bit("partial_idle", bus.busy, 1'b0);
        tick();
        check_drained("partial_byte");
    endtask

    task automatic test_eop_on_last();
        logic [7:0] v;
        v = 8'h5A;
        pulse_start();
        for (int i = 0; i < 7; i++) send_bit(v[i]);
        bus.d_orig = v[7]; bus.shift_strobe = 1'b1; bus.eop = 1'b1; align_exp = 1'b1;
        tick();
        bus.shift_strobe = 1'b0; bus.eop = 1'b0;
        tick();
        tick();
        check_bit("eoplast_idle", bus.busy, 1'b0);
        check_drained("eoplast_no_byte");
    endtask

    task automatic test_restart();
        pulse_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        pulse_start();
        send_byte(8'h96);
        check_drained("restart_byte");
        do_eop(1'b0);
    endtask

    task automatic test_back_to_back();
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        check_drained("b2b_bytes");
        do_eop(1'b0);
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL arst_rx_byte: got %h expected 00", bus.rx_byte);
        end
        check_bit("arst_busy", bus.busy, 1'b0);
        check_bit("arst_stuff_err", bus.stuff_err, 1'b0);
        check_bit("arst_align_err", bus.align_err, 1'b0);
        check_bit("arst_byte_ready", bus.byte_ready, 1'b0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        pulse_start();
        send_byte(8'h01);
        check_drained("arst_after_byte");
        checks++;
        if (bus.rx_byte !== 8'h01) begin
            errors++;
            $display("FAIL arst_hold: got %h expected 01", bus.rx_byte);
        end
        do_eop(1'b0);
    endtask

    initial begin
        test_reset();
        test_byte_a5();
        test_stuff_drop();
        test_stuff_violation();
        test_partial_eop();
        test_eop_on_last();
        test_restart();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
